hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV64 pipeline (F/D/E/M/W).
//  - Owns the ibus fetch handshake and parks a pending branch redirect.
//  - Detects load-use hazards.
//  - Converts dbus wait and branch redirect into per-register hold/bubble controls.
//  - Replaces the free-running pc_reg advance with a controlled pc_we/pc_src.
// PARAMETERS
//  PERF_W   32  width of saturating performance counters
//  XLEN     64  pc / redirect target width
// PORTS
//  clk           in   1     clock
//  reset         in   1     asynchronous, active-high reset
//  iresp_data_ok in   1     ibus returns instruction this cycle
//  ireq_valid    out  1     ibus request valid; core drives ireq.addr from pc
//  mem_req       in   1     M-stage instruction is a load/store (dreq.valid)
//  dresp_data_ok in   1     dbus access completes this cycle
//  e_is_load     in   1     decode_reg holds a load
//  e_rd          in   5     destination register of that load
//  d_rs1, d_rs2  in   5     sources read by the instruction in decode
//  d_use1,d_use2 in   1     decode actually reads rs1 / rs2
//  e_redirect    in   1     execute resolved taken branch/jump
//  e_target      in   XLEN  redirect target
//  pc_we         out  1     pc register loads next value
//  pc_src        out  1     0: pc+4; 1: pc_target
//  pc_target     out  XLEN  redirect address
//  hold_fd, hold_de, hold_em   out 1 each  fetch_reg / decode_reg / execute_reg keep contents
//  bubble_fd, bubble_de, bubble_em, bubble_mw  out 1 each  register loads a NOP
//  perf_mem, perf_lu, perf_flush  out PERF_W each  stall/flush counters
// BEHAVIOUR
//  Fetch FSM, state reg, async reset -> F_IDLE:
//  - F_IDLE: ireq_valid=0, bubble_fd=1; next cycle -> F_BUSY.
//  - F_BUSY: ireq_valid=1, pc held until iresp_data_ok.
//  - F_PEND: a redirect was parked; ireq_valid=1 for the old pc. On data_ok: drop the instruction (bubble_fd), pc<=pend_pc -> F_BUSY.
//  - fetch_done = iresp_data_ok & state!=F_IDLE.
//  - pend_pc/pend_v regs; reset pend_v=0, pend_pc=0.
//  mem_busy = mem_req & ~dresp_data_ok; lu = e_is_load & e_rd!=0 & ((d_use1&d_rs1==e_rd)|(d_use2&d_rs2==e_rd)).
//  Priority per cycle (highest first):
//  1 mem_busy: hold_fd=hold_de=hold_em=1, bubble_mw=1, pc_we=0. Redirect ignored (it stays asserted, decode_reg held). The fetch FSM still tracks data_ok; a returned instr is held in a 1-entry skid reg (ibuf) and consumed when the stall ends.
//  2 e_redirect: bubble_fd=bubble_de=1.
//     - If fetch_done this cycle: pc_we=1, pc_src=1, pc_target=e_target, stay F_BUSY.
//     - Else: park pend_pc=e_target, pend_v=1, -> F_PEND; pc_we=0.
//  3 lu: hold_fd=1, bubble_de=1, pc_we=0. A fetch completing now fills ibuf.
//  4 fetch not done and ibuf empty: bubble_fd=1, pc_we=0.
//  5 else: pc_we=1, pc_src=0, all holds/bubbles 0; fetch_reg takes ibuf if valid, else iresp.
//  - ibuf holds at most one instr. The pc does not advance while ibuf is full, so it cannot overflow.
//  - A redirect flushes ibuf.
//  - Exactly one request in flight at any time. A second redirect while in F_PEND overwrites pend_pc (last wins).
//  - pc_target = pend_pc when leaving F_PEND, else e_target.
//  - Reset mid-operation: FSM -> F_IDLE, pend_v=0, ibuf invalid. While reset is high: bubble_* = 1, hold_* = 0, ireq_valid=0, pc_we=0. Counters reset to 0.
// CONFIGURATION
//  HAZARD_PERF_EN defined: counters increment (saturating at 2^PERF_W-1):
//  - perf_mem on mem_busy cycles;
//  - perf_lu on cycles where lu wins;
//  - perf_flush on every accepted redirect (case 2).
//  Undefined: counter regs absent, perf_* tied to 0; ports retained.
// STRUCTURE
//  - pipes package gains: fetch_state_t enum {F_IDLE,F_BUSY,F_PEND}, and struct pipe_ctrl_t {hold_fd,hold_de,hold_em,bubble_fd,bubble_de,bubble_em,bubble_mw}, NOP_INSTR=32'h00000013.
//  - Sub-module load_use_detect (combinational lu comparator) is instantiated once.
//  - FSM, ibuf, pend regs and counters live in hazard_ctrl.
// TESTING
//  1 Reset pulse mid-F_PEND -> next cycle ireq_valid=0, pend_v=0, all bubble_*=1; F_BUSY one cycle after reset deasserts.
//  2 ld x5 in E, add reading x5 in D -> exactly 1 cycle: hold_fd=1, bubble_de=1, pc_we=0; x0 as rd -> no stall.
//  3 mem_req=1, dresp_data_ok low for 3 cycles -> 3 cycles hold_fd/de/em=1, bubble_mw=1. An instr arriving meanwhile sits in ibuf and issues with no refetch.
//  4 Redirect to 0x8000_0100 with data_ok same cycle -> pc_we=1, pc_src=1, bubble_fd=bubble_de=1.
//  5 Redirect to 0x8000_0200 while fetch awaits data_ok for 2 more cycles -> F_PEND; stale instr dropped; next ireq at 0x8000_0200.
//  6 HAZARD_PERF_EN, 4 mem-stall + 1 lu + 2 redirects -> perf_mem=4, perf_lu=1, perf_flush=2; without macro all 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared types for the pipeline hazard/stall sequencer.
//   fetch_state_t : ibus fetch FSM encoding
//   pipe_ctrl_t   : per-pipeline-register hold/bubble bundle
//   NOP_INSTR     : encoding loaded by a bubbled register (addi x0,x0,0)
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_BUSY = 2'd1,
        F_PEND = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic hold_fd;
        logic hold_de;
        logic hold_em;
        logic bubble_fd;
        logic bubble_de;
        logic bubble_em;
        logic bubble_mw;
    } pipe_ctrl_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam pipe_ctrl_t CTRL_NONE = 7'b000_0000;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use comparator: flags when the instruction in decode
// reads the destination of a load currently in execute. x0 never hazards.
// Ports:
//   i_e_is_load, i_e_rd       load in execute and its destination
//   i_d_rs1/2, i_d_use1/2     decode sources and whether they are read
//   o_lu                      hazard present
// ---------------------------------------------------------------------------
module load_use_detect (
    input  logic       i_e_is_load,
    input  logic [4:0] i_e_rd,
    input  logic [4:0] i_d_rs1,
    input  logic [4:0] i_d_rs2,
    input  logic       i_d_use1,
    input  logic       i_d_use2,
    output logic       o_lu
);

    logic w_rd_nz;
    logic w_hit1;
    logic w_hit2;

    assign w_rd_nz = (i_e_rd != 5'd0);
    assign w_hit1  = i_d_use1 & (i_d_rs1 == i_e_rd);
    assign w_hit2  = i_d_use2 & (i_d_rs2 == i_e_rd);
    assign o_lu    = i_e_is_load & w_rd_nz & (w_hit1 | w_hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush sequencer for the 5-stage F/D/E/M/W pipeline. Owns the ibus
// fetch handshake, parks redirects that arrive while a fetch is in flight,
// detects load-use hazards and turns dbus wait / redirects into per-register
// hold and bubble controls plus a controlled pc update.
//
// Optional feature: define HAZARD_PERF_EN to build the saturating stall/flush
// performance counters; otherwise perf_* are tied to zero.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   iresp_data_ok / ireq_valid  ibus handshake
//   mem_req, dresp_data_ok      dbus stall source
//   e_is_load, e_rd, d_rs1/2, d_use1/2   load-use inputs
//   e_redirect, e_target        branch/jump resolution from execute
//   pc_we, pc_src, pc_target    pc register control
//   hold_*, bubble_*            pipeline register control
//   perf_mem, perf_lu, perf_flush        performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int PERF_W = 32,
    parameter int XLEN   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iresp_data_ok,
    output logic              ireq_valid,
    input  logic              mem_req,
    input  logic              dresp_data_ok,
    input  logic              e_is_load,
    input  logic [4:0]        e_rd,
    input  logic [4:0]        d_rs1,
    input  logic [4:0]        d_rs2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic              e_redirect,
    input  logic [XLEN-1:0]   e_target,
    output logic              pc_we,
    output logic              pc_src,
    output logic [XLEN-1:0]   pc_target,
    output logic              hold_fd,
    output logic              hold_de,
    output logic              hold_em,
    output logic              bubble_fd,
    output logic              bubble_de,
    output logic              bubble_em,
    output logic              bubble_mw,
    output logic [PERF_W-1:0] perf_mem,
    output logic [PERF_W-1:0] perf_lu,
    output logic [PERF_W-1:0] perf_flush
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            r_ibuf_v;
    logic            w_ibuf_nxt;
    logic            r_pend_v;
    logic            w_pend_v_nxt;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] w_pend_pc_nxt;

    logic            w_lu;
    logic            w_mem_busy;
    logic            w_ireq_valid;
    logic            w_fetch_done;
    logic            w_pend_done;
    logic            w_take_pend;

    pipe_ctrl_t      w_ctrl;
    logic            w_pc_we;
    logic            w_pc_src;
    logic [XLEN-1:0] w_pc_target;

    load_use_detect u_lu (
        .i_e_is_load (e_is_load),
        .i_e_rd      (e_rd),
        .i_d_rs1     (d_rs1),
        .i_d_rs2     (d_rs2),
        .i_d_use1    (d_use1),
        .i_d_use2    (d_use2),
        .o_lu        (w_lu)
    );

    assign w_mem_busy = mem_req & ~dresp_data_ok;

    // While ibuf holds a fetched instruction the pc still points at it, so
    // requesting again would only refetch the same word; the bus is idle
    // until ibuf drains.
    assign w_ireq_valid = (r_state == F_PEND) | ((r_state == F_BUSY) & ~r_ibuf_v);
    assign w_fetch_done = iresp_data_ok & w_ireq_valid;
    assign w_pend_done  = iresp_data_ok & (r_state == F_PEND) & r_pend_v;

    always_comb begin
        w_ctrl        = CTRL_NONE;
        w_pc_we       = 1'b0;
        w_pc_src      = 1'b0;
        w_pc_target   = e_target;
        w_state_nxt   = r_state;
        w_ibuf_nxt    = r_ibuf_v;
        w_pend_v_nxt  = r_pend_v;
        w_pend_pc_nxt = r_pend_pc;
        w_take_pend   = 1'b0;

        if (r_state == F_IDLE) begin
            w_state_nxt = F_BUSY;
        end

        if (w_mem_busy) begin
            w_ctrl.hold_fd   = 1'b1;
            w_ctrl.hold_de   = 1'b1;
            w_ctrl.hold_em   = 1'b1;
            w_ctrl.bubble_mw = 1'b1;
            // The stale instruction of a parked redirect is dropped even
            // during a dbus stall; loading the pc touches no pipeline register.
            if (w_pend_done) begin
                w_take_pend = 1'b1;
            end else if (w_fetch_done) begin
                w_ibuf_nxt = 1'b1;
            end
        end else if (e_redirect) begin
            w_ctrl.bubble_fd = 1'b1;
            w_ctrl.bubble_de = 1'b1;
            w_ibuf_nxt       = 1'b0;
            // With no request outstanding (ibuf full or idle) nothing needs
            // to be drained, so the redirect can load the pc at once.
            if (w_fetch_done || !w_ireq_valid) begin
                w_pc_we      = 1'b1;
                w_pc_src     = 1'b1;
                w_state_nxt  = F_BUSY;
                w_pend_v_nxt = 1'b0;
            end else begin
                w_pend_pc_nxt = e_target;
                w_pend_v_nxt  = 1'b1;
                w_state_nxt   = F_PEND;
            end
        end else if (w_lu) begin
            w_ctrl.hold_fd   = 1'b1;
            w_ctrl.bubble_de = 1'b1;
            if (w_pend_done) begin
                w_take_pend = 1'b1;
            end else if (w_fetch_done) begin
                w_ibuf_nxt = 1'b1;
            end
        end else if (r_state == F_PEND) begin
            w_ctrl.bubble_fd = 1'b1;
            w_take_pend      = w_pend_done;
        end else if (w_fetch_done || r_ibuf_v) begin
            w_pc_we    = 1'b1;
            w_ibuf_nxt = 1'b0;
        end else begin
            w_ctrl.bubble_fd = 1'b1;
        end

        if (w_take_pend) begin
            w_pc_we      = 1'b1;
            w_pc_src     = 1'b1;
            w_pc_target  = r_pend_pc;
            w_state_nxt  = F_BUSY;
            w_pend_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= F_IDLE;
            r_ibuf_v  <= 1'b0;
            r_pend_v  <= 1'b0;
            r_pend_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ibuf_v  <= w_ibuf_nxt;
            r_pend_v  <= w_pend_v_nxt;
            r_pend_pc <= w_pend_pc_nxt;
        end
    end

    // Reset forces a safe pipeline: everything bubbles, nothing holds or fetches.
    assign ireq_valid = ~reset & w_ireq_valid;
    assign pc_we      = ~reset & w_pc_we;
    assign pc_src     = ~reset & w_pc_src;
    assign pc_target  = w_pc_target;
    assign hold_fd    = ~reset & w_ctrl.hold_fd;
    assign hold_de    = ~reset & w_ctrl.hold_de;
    assign hold_em    = ~reset & w_ctrl.hold_em;
    assign bubble_fd  = reset | w_ctrl.bubble_fd;
    assign bubble_de  = reset | w_ctrl.bubble_de;
    assign bubble_em  = reset | w_ctrl.bubble_em;
    assign bubble_mw  = reset | w_ctrl.bubble_mw;

`ifdef HAZARD_PERF_EN
    logic              w_cnt_mem;
    logic              w_cnt_lu;
    logic              w_cnt_flush;
    logic [PERF_W-1:0] r_perf_mem;
    logic [PERF_W-1:0] r_perf_lu;
    logic [PERF_W-1:0] r_perf_flush;

    assign w_cnt_mem   = w_mem_busy;
    assign w_cnt_lu    = ~w_mem_busy & ~e_redirect & w_lu;
    assign w_cnt_flush = ~w_mem_busy & e_redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_mem   <= '0;
            r_perf_lu    <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_cnt_mem && (r_perf_mem != '1)) begin
                r_perf_mem <= r_perf_mem + PERF_W'(1);
            end
            if (w_cnt_lu && (r_perf_lu != '1)) begin
                r_perf_lu <= r_perf_lu + PERF_W'(1);
            end
            if (w_cnt_flush && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + PERF_W'(1);
            end
        end
    end

    assign perf_mem   = r_perf_mem;
    assign perf_lu    = r_perf_lu;
    assign perf_flush = r_perf_flush;
`else
    assign perf_mem   = '0;
    assign perf_lu    = '0;
    assign perf_flush = '0;
`endif

endmodule
